keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_if.sv | 20 ++
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Signal bundle between a 3x4 matrix keypad scanner and its host/keypad side.
// The scanner takes the slave view; the host and keypad take the master view.
interface keypad_scanner_if;
  logic       scan_en;
  logic [3:0] row_in;
  logic [2:0] col_drive;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    output scan_en, row_in,
    input  col_drive, key_valid, key_code, key_held
  );

  modport slave (
    input  scan_en, row_in,
    output col_drive, key_valid, key_code, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 3-column x 4-row keypad scanner with a synchronized row input, press/release
// debouncing, and a single key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input logic             clk,
  input logic             reset,
  keypad_scanner_if.slave kp
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [15:0] DWELL_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] STABLE_LAST = 16'(DEBOUNCE_CNT - 1);

  state_t      state;
  logic [3:0]  sync1;
  logic [3:0]  rs;
  logic [1:0]  col_idx;
  logic [15:0] dwell_cnt;
  logic [15:0] stable_cnt;
  logic [3:0]  row_latch;
  logic        rs_one_hot;

  assign rs_one_hot = (rs != 4'b0000) && ((rs & (rs - 4'b0001)) == 4'b0000);

  function automatic logic [2:0] col_one_hot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] col_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [3:0] key_map(input logic [3:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case (row)
      4'b0001: code = 4'(col) + 4'h1;
      4'b0010: code = 4'(col) + 4'h4;
      4'b0100: code = 4'(col) + 4'h7;
      4'b1000: code = (col == 2'd0) ? 4'hA : ((col == 2'd1) ? 4'h0 : 4'hB);
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'b0000;
      rs    <= 4'b0000;
    end else begin
      sync1 <= kp.row_in;
      rs    <= sync1;
    end
  end

  // Counters only advance below their terminal value, so they saturate.
  // col_drive of 000 in SCAN means the scanner was idle and must start col1 fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SCAN;
      col_idx      <= 2'd0;
      dwell_cnt    <= 16'd0;
      stable_cnt   <= 16'd0;
      row_latch    <= 4'b0000;
      kp.col_drive <= 3'b000;
      kp.key_valid <= 1'b0;
      kp.key_code  <= 4'h0;
      kp.key_held  <= 1'b0;
    end else begin
      kp.key_valid <= 1'b0;
      if (!kp.scan_en) begin
        state        <= SCAN;
        col_idx      <= 2'd0;
        dwell_cnt    <= 16'd0;
        stable_cnt   <= 16'd0;
        kp.col_drive <= 3'b000;
        kp.key_held  <= 1'b0;
      end else begin
        case (state)
          SCAN: begin
            if (kp.col_drive == 3'b000) begin
              col_idx      <= 2'd0;
              dwell_cnt    <= 16'd0;
              kp.col_drive <= 3'b001;
            end else if (dwell_cnt >= DWELL_LAST) begin
              if (rs_one_hot) begin
                row_latch  <= rs;
                stable_cnt <= 16'd0;
                state      <= DEBOUNCE;
              end else begin
                col_idx      <= col_next(col_idx);
                kp.col_drive <= col_one_hot(col_next(col_idx));
                dwell_cnt    <= 16'd0;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 16'd1;
            end
          end

          DEBOUNCE: begin
            if (rs == row_latch) begin
              if (stable_cnt >= STABLE_LAST) begin
                kp.key_valid <= 1'b1;
                kp.key_code  <= key_map(row_latch, col_idx);
                kp.key_held  <= 1'b1;
                stable_cnt   <= 16'd0;
                state        <= HELD;
              end else begin
                stable_cnt <= stable_cnt + 16'd1;
              end
            end else begin
              col_idx      <= col_next(col_idx);
              kp.col_drive <= col_one_hot(col_next(col_idx));
              dwell_cnt    <= 16'd0;
              stable_cnt   <= 16'd0;
              state        <= SCAN;
            end
          end

          HELD: begin
            if (rs == 4'b0000) begin
              stable_cnt <= 16'd1;
              state      <= RELEASE;
            end
          end

          RELEASE: begin
            if (rs != 4'b0000) begin
              stable_cnt <= 16'd0;
              state      <= HELD;
            end else if (stable_cnt >= STABLE_LAST) begin
              stable_cnt   <= 16'd0;
              dwell_cnt    <= 16'd0;
              col_idx      <= 2'd0;
              kp.col_drive <= 3'b001;
              kp.key_held  <= 1'b0;
              state        <= SCAN;
            end else begin
              stable_cnt <= stable_cnt + 16'd1;
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus queues expected key codes,
// a negedge monitor pops and compares them whenever key_valid pulses.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp_if.slave)
  );

  // Keypad model: a pressed key connects its row(s) to its column while driven.
  logic       key_down   = 1'b0;
  logic [3:0] key_row    = 4'b0000;
  logic [2:0] key_col    = 3'b000;
  logic       force_mode = 1'b1;
  logic [3:0] force_row  = 4'b0000;

  assign kp_if.row_in = force_mode ? force_row :
                        ((key_down && ((kp_if.col_drive & key_col) != 3'b000)) ? key_row : 4'b0000);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  int valid_count = 0;
  logic prev_valid = 1'b0;
  logic [3:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (reset && kp_if.key_valid) begin
      check_output("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_key_valid: got code %0h, expected no pulse", kp_if.key_code);
      end else begin
        check_output("key_code", {28'd0, kp_if.key_code}, {28'd0, exp_q.pop_front()});
      end
      last_valid_cyc = cyc;
      valid_count++;
    end
    prev_valid = kp_if.key_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [2:0] c, input string name);
    int n = 0;
    while (kp_if.col_drive === c && n < 100) begin tick(1); n++; end
    while (kp_if.col_drive !== c && n < 100) begin tick(1); n++; end
    check_output(name, {29'd0, kp_if.col_drive}, {29'd0, c});
  endtask

  task automatic wait_held(input logic val, input int budget, input string name);
    int n = 0;
    while (kp_if.key_held !== val && n < budget) begin tick(1); n++; end
    check_output(name, {31'd0, kp_if.key_held}, {31'd0, val});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_col_drive"}, {29'd0, kp_if.col_drive}, 32'd0);
    check_output({tag, "_key_valid"}, {31'd0, kp_if.key_valid}, 32'd0);
    check_output({tag, "_key_code"},  {28'd0, kp_if.key_code},  32'd0);
    check_output({tag, "_key_held"},  {31'd0, kp_if.key_held},  32'd0);
  endtask

  task automatic apply_stimulus();
    int e0;
    int z0;
    int vc;

    // Reset state, then first column on the first edge after release
    kp_if.scan_en = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk) reset = 1'b1;
    tick(1);
    check_output("first_col_after_reset", {29'd0, kp_if.col_drive}, 32'd1);

    // Idle scan: each column driven for SCAN_DIV edges
    for (int k = 1; k < 24; k++) begin
      tick(1);
      check_output("idle_scan_col", {29'd0, kp_if.col_drive}, {29'd0, 3'b001 << ((k / 4) % 3)});
    end

    // Key 5: row reaches the synchronizer two edges before col2's last dwell edge
    wait_col(3'b010, "reach_col2");
    tick(1);
    force_row = 4'b0010;
    e0 = cyc + 1;
    exp_q.push_back(4'h5);
    wait_held(1'b1, 30, "key5_held");
    tick(1);
    check_output("key5_latency", last_valid_cyc - e0, 32'd10);
    check_output("key5_col_frozen", {29'd0, kp_if.col_drive}, 32'b010);
    tick(10);
    force_row = 4'b0100;
    tick(5);
    check_output("held_ignores_other_row", {31'd0, kp_if.key_held}, 32'd1);
    force_row = 4'b0010;
    tick(5);

    // Release glitch: 5 zeros, 1 high, then zeros; final release needs 8 zero evaluations
    force_row = 4'b0000;
    tick(5);
    force_row = 4'b0010;
    tick(1);
    force_row = 4'b0000;
    z0 = cyc + 1;
    tick(9);
    check_output("release_not_yet", {31'd0, kp_if.key_held}, 32'd1);
    check_output("release_edge_count", cyc - z0, 32'd8);
    tick(1);
    check_output("release_done", {31'd0, kp_if.key_held}, 32'd0);
    check_output("release_col1", {29'd0, kp_if.col_drive}, 32'b001);

    // Bouncing star key, then stable
    force_mode = 1'b0;
    key_row = 4'b1000;
    key_col = 3'b001;
    vc = valid_count;
    for (int i = 0; i < 10; i++) begin
      key_down = ~key_down;
      tick(3);
    end
    check_output("bounce_no_valid", valid_count - vc, 32'd0);
    key_down = 1'b1;
    exp_q.push_back(4'hA);
    wait_held(1'b1, 60, "star_held");
    key_down = 1'b0;
    wait_held(1'b0, 40, "star_released");

    // Ghost: two rows on col3 never captured
    key_row = 4'b0110;
    key_col = 3'b100;
    key_down = 1'b1;
    vc = valid_count;
    tick(36);
    check_output("ghost_no_valid", valid_count - vc, 32'd0);
    check_output("ghost_not_held", {31'd0, kp_if.key_held}, 32'd0);
    wait_col(3'b100, "ghost_scan_col3");
    wait_col(3'b001, "ghost_scan_wraps");
    key_down = 1'b0;

    // Reset mid-DEBOUNCE on key 8
    key_row = 4'b0100;
    key_col = 3'b010;
    wait_col(3'b010, "key8_col2");
    key_down = 1'b1;
    tick(7);
    vc = valid_count;
    #2 reset = 1'b0;
    #1 check_reset_outputs("abort_reset");
    key_down = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick(1);
    check_output("abort_restart_col1", {29'd0, kp_if.col_drive}, 32'b001);
    tick(12);
    check_output("abort_no_valid", valid_count - vc, 32'd0);

    // scan_en dropped mid-HELD on key 9
    key_row = 4'b0100;
    key_col = 3'b100;
    key_down = 1'b1;
    exp_q.push_back(4'h9);
    wait_held(1'b1, 60, "key9_held");
    tick(3);
    kp_if.scan_en = 1'b0;
    tick(1);
    check_output("disable_col_drive", {29'd0, kp_if.col_drive}, 32'd0);
    check_output("disable_key_held", {31'd0, kp_if.key_held}, 32'd0);
    check_output("disable_key_code", {28'd0, kp_if.key_code}, 32'h9);
    key_down = 1'b0;
    tick(2);
    check_output("disabled_idle", {29'd0, kp_if.col_drive}, 32'd0);
    kp_if.scan_en = 1'b1;
    tick(1);
    check_output("enable_col1", {29'd0, kp_if.col_drive}, 32'b001);
    tick(3);
    check_output("enable_full_dwell", {29'd0, kp_if.col_drive}, 32'b001);
    tick(1);
    check_output("enable_next_col", {29'd0, kp_if.col_drive}, 32'b010);

    tick(5);
    check_output("all_presses_seen", exp_q.size(), 32'd0);
  endtask

  initial begin
    kp_if.scan_en = 1'b0;
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
